// File: rtl/eco32_core_fpu_wb_sink.sv
// FPU write-back sink: captures write-backs from the FPU bus (which has no
// backpressure), queues them, and presents them in order to the register-file
// write port through a req/ack handshake. Each completed write is followed by
// a one-cycle scoreboard-release pulse carrying its thread and tag.
module eco32_core_fpu_wb_sink #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_stb0,
    input  logic          wb_stb1,
    input  logic [1:0]    wb_enaA,
    input  logic          wb_tagA,
    input  logic [1:0]    wb_enaB,
    input  logic          wb_tagB,
    input  logic          wb_modB,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_dataL,
    input  logic [31:0]   wb_dataH,
    output logic          rf_req,
    input  logic          rf_ack,
    output logic          rf_tid,
    output logic [1:0]    rf_ena,
    output logic          rf_mod,
    output logic [4:0]    rf_addr,
    output logic [31:0]   rf_dataL,
    output logic [31:0]   rf_dataH,
    output logic          sb_clr_stb,
    output logic          sb_clr_tid,
    output logic          sb_clr_tag,
    output logic [AW:0]   fifo_lvl,
    output logic          err_ovf,
    output logic          err_proto
);

    // Entry layout: {tid, ena[1:0], tag, mod, addr[4:0], dataH, dataL}
    localparam int EW = 74;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   fcnt_r;      // entries waiting behind the output register
    logic [AW:0]   lvl_r;       // fcnt_r plus the output register
    logic          out_vld_r;
    logic [EW-1:0] out_r;

    logic          cap_s;
    logic          proto_s;
    logic          tid_s;
    logic [EW-1:0] entry_s;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          ovf_s;
    logic          load_s;
    logic          from_fifo_s;
    logic          to_fifo_s;
    logic          bypass_s;

    // Decode the incoming write-back and steer it to the FIFO or the output register.
    always_comb begin
        cap_s       = (wb_stb0 | wb_stb1) && ((|wb_enaA) || (|wb_enaB));
        proto_s     = cap_s && (|wb_enaA) && (|wb_enaB);
        tid_s       = |wb_enaB;
        entry_s     = {tid_s,
                       tid_s ? wb_enaB : wb_enaA,
                       tid_s ? wb_tagB : wb_tagA,
                       tid_s & wb_modB,
                       wb_addr, wb_dataH, wb_dataL};
        pop_s       = out_vld_r && rf_ack;
        full_s      = (lvl_r == LVL_FULL);
        push_s      = cap_s && !proto_s && (!full_s || pop_s);
        ovf_s       = cap_s && !proto_s && full_s && !pop_s;
        load_s      = !out_vld_r || pop_s;
        from_fifo_s = 1'b0;
        to_fifo_s   = 1'b0;
        bypass_s    = 1'b0;
        if (load_s) begin
            if (fcnt_r != '0) begin
                from_fifo_s = 1'b1;
                to_fifo_s   = push_s;
            end else begin
                bypass_s    = push_s;
            end
        end else begin
            to_fifo_s = push_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && to_fifo_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers, occupancy, output register, release pulse and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fcnt_r     <= '0;
            lvl_r      <= '0;
            out_vld_r  <= 1'b0;
            out_r      <= '0;
            sb_clr_stb <= 1'b0;
            sb_clr_tid <= 1'b0;
            sb_clr_tag <= 1'b0;
            err_ovf    <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            wr_ptr_r <= to_fifo_s   ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
            rd_ptr_r <= from_fifo_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
            fcnt_r   <= fcnt_r + {{AW{1'b0}}, to_fifo_s} - {{AW{1'b0}}, from_fifo_s};
            lvl_r    <= lvl_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
            if (load_s) begin
                out_vld_r <= from_fifo_s | bypass_s;
                if (from_fifo_s) begin
                    out_r <= mem_r[rd_ptr_r];
                end else if (bypass_s) begin
                    out_r <= entry_s;
                end else begin
                    out_r <= out_r;
                end
            end
            // Release follows the completed handshake by exactly one cycle.
            sb_clr_stb <= pop_s;
            if (pop_s) begin
                sb_clr_tid <= out_r[73];
                sb_clr_tag <= out_r[70];
            end
            err_ovf   <= err_ovf | ovf_s;
            err_proto <= err_proto | proto_s;
        end
    end

    assign rf_req   = out_vld_r;
    assign rf_tid   = out_r[73];
    assign rf_ena   = out_r[72:71];
    assign rf_mod   = out_r[69];
    assign rf_addr  = out_r[68:64];
    assign rf_dataH = out_r[63:32];
    assign rf_dataL = out_r[31:0];
    assign fifo_lvl = lvl_r;

endmodule

// File: tb/tb_eco32_core_fpu_wb_sink.sv
// Bench for eco32_core_fpu_wb_sink: a cycle model with an expected-entry queue
// checks every output on each falling edge, while scenario tasks add directed
// checks for the key behaviours.
module tb_eco32_core_fpu_wb_sink;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_stb0 = 1'b0, wb_stb1 = 1'b0;
    logic [1:0]  wb_enaA = 2'b00, wb_enaB = 2'b00;
    logic        wb_tagA = 1'b0, wb_tagB = 1'b0, wb_modB = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_dataL = 32'd0, wb_dataH = 32'd0;
    logic        rf_ack = 1'b0;
    logic        rf_req, rf_tid, rf_mod;
    logic [1:0]  rf_ena;
    logic [4:0]  rf_addr;
    logic [31:0] rf_dataL, rf_dataH;
    logic        sb_clr_stb, sb_clr_tid, sb_clr_tag;
    logic [AW:0] fifo_lvl;
    logic        err_ovf, err_proto;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        tid;
        logic [1:0]  ena;
        logic        tag;
        logic        mod;
        logic [4:0]  addr;
        logic [31:0] dl;
        logic [31:0] dh;
    } ent_t;

    ent_t q[$];
    logic m_ovf = 1'b0, m_proto = 1'b0;
    logic m_sb_stb = 1'b0, m_sb_tid = 1'b0, m_sb_tag = 1'b0;

    eco32_core_fpu_wb_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wb_stb0(wb_stb0), .wb_stb1(wb_stb1),
        .wb_enaA(wb_enaA), .wb_tagA(wb_tagA),
        .wb_enaB(wb_enaB), .wb_tagB(wb_tagB), .wb_modB(wb_modB),
        .wb_addr(wb_addr), .wb_dataL(wb_dataL), .wb_dataH(wb_dataH),
        .rf_req(rf_req), .rf_ack(rf_ack), .rf_tid(rf_tid), .rf_ena(rf_ena),
        .rf_mod(rf_mod), .rf_addr(rf_addr), .rf_dataL(rf_dataL), .rf_dataH(rf_dataH),
        .sb_clr_stb(sb_clr_stb), .sb_clr_tid(sb_clr_tid), .sb_clr_tag(sb_clr_tag),
        .fifo_lvl(fifo_lvl), .err_ovf(err_ovf), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    // Reference model: compare outputs against model state, then advance it.
    always @(negedge clk) begin : model
        ent_t e;
        ent_t got;
        logic pop_m, full_m, cap_m, prot_m;
        n_tests++;
        if (rf_req !== (q.size() > 0)) begin
            n_fail++; $display("FAIL mon_req: got %b want %b", rf_req, (q.size() > 0));
        end
        n_tests++;
        if (fifo_lvl !== 3'(q.size())) begin
            n_fail++; $display("FAIL mon_lvl: got %0d want %0d", fifo_lvl, q.size());
        end
        n_tests++;
        if ({err_ovf, err_proto} !== {m_ovf, m_proto}) begin
            n_fail++; $display("FAIL mon_err: got %b%b want %b%b", err_ovf, err_proto, m_ovf, m_proto);
        end
        n_tests++;
        if ({sb_clr_stb, sb_clr_tid, sb_clr_tag} !== {m_sb_stb, m_sb_tid, m_sb_tag}) begin
            n_fail++; $display("FAIL mon_sb: got %b%b%b want %b%b%b", sb_clr_stb, sb_clr_tid, sb_clr_tag, m_sb_stb, m_sb_tid, m_sb_tag);
        end
        if (q.size() > 0) begin
            got = {rf_tid, rf_ena, 1'b0, rf_mod, rf_addr, rf_dataL, rf_dataH};
            e = q[0];
            e.tag = 1'b0;
            n_tests++;
            if (got !== e) begin
                n_fail++; $display("FAIL mon_entry: got %h want %h", got, e);
            end
        end
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_proto = 1'b0;
            m_sb_stb = 1'b0; m_sb_tid = 1'b0; m_sb_tag = 1'b0;
        end else begin
            full_m = (q.size() == DEPTH);
            pop_m  = (q.size() > 0) && rf_ack;
            m_sb_stb = pop_m;
            if (pop_m) begin
                m_sb_tid = q[0].tid;
                m_sb_tag = q[0].tag;
                void'(q.pop_front());
            end
            cap_m  = (wb_stb0 | wb_stb1) && ((|wb_enaA) || (|wb_enaB));
            prot_m = (|wb_enaA) && (|wb_enaB);
            if (cap_m && prot_m) begin
                m_proto = 1'b1;
            end else if (cap_m) begin
                if (!full_m || pop_m) begin
                    e.tid  = |wb_enaB;
                    e.ena  = e.tid ? wb_enaB : wb_enaA;
                    e.tag  = e.tid ? wb_tagB : wb_tagA;
                    e.mod  = e.tid & wb_modB;
                    e.addr = wb_addr;
                    e.dl   = wb_dataL;
                    e.dh   = wb_dataH;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic drv(input logic s0, input logic s1, input logic [1:0] ea, input logic ta,
                       input logic [1:0] eb, input logic tg_b, input logic mb,
                       input logic [4:0] ad, input logic [31:0] dl, input logic [31:0] dh);
        @(posedge clk); #1;
        wb_stb0 = s0; wb_stb1 = s1; wb_enaA = ea; wb_tagA = ta;
        wb_enaB = eb; wb_tagB = tg_b; wb_modB = mb; wb_addr = ad;
        wb_dataL = dl; wb_dataH = dh;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({rf_req, fifo_lvl, err_ovf, err_proto, sb_clr_stb} !== 7'b0) begin
            n_fail++; $display("FAIL reset_state: got %b%0d%b%b%b want all 0", rf_req, fifo_lvl, err_ovf, err_proto, sb_clr_stb);
        end
    endtask

    task automatic test_single();
        rf_ack = 1'b1;
        drv(1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 5'd5, 32'h1111, 32'h2222);
        idle();
        @(negedge clk);
        n_tests++;
        if ({rf_req, rf_tid, rf_ena, rf_addr, rf_dataL, rf_dataH} !== {1'b1, 1'b0, 2'b11, 5'd5, 32'h1111, 32'h2222}) begin
            n_fail++; $display("FAIL single_rf: got req=%b tid=%b ena=%0d addr=%0d L=%h H=%h want 1 0 3 5 1111 2222", rf_req, rf_tid, rf_ena, rf_addr, rf_dataL, rf_dataH);
        end
        idle();
        @(negedge clk);
        n_tests++;
        if ({sb_clr_stb, sb_clr_tid, sb_clr_tag} !== 3'b101) begin
            n_fail++; $display("FAIL single_sb: got %b%b%b want 101", sb_clr_stb, sb_clr_tid, sb_clr_tag);
        end
    endtask

    task automatic test_thread_b();
        rf_ack = 1'b1;
        drv(1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 5'd31, 32'hA5A5_0001, 32'h5A5A_0002);
        idle();
        @(negedge clk);
        n_tests++;
        if ({rf_req, rf_tid, rf_ena, rf_mod, rf_addr} !== {1'b1, 1'b1, 2'b01, 1'b1, 5'd31}) begin
            n_fail++; $display("FAIL threadb_rf: got req=%b tid=%b ena=%0d mod=%b addr=%0d want 1 1 1 1 31", rf_req, rf_tid, rf_ena, rf_mod, rf_addr);
        end
        idle();
        @(negedge clk);
        n_tests++;
        if ({sb_clr_stb, sb_clr_tid, sb_clr_tag} !== 3'b110) begin
            n_fail++; $display("FAIL threadb_sb: got %b%b%b want 110", sb_clr_stb, sb_clr_tid, sb_clr_tag);
        end
    endtask

    task automatic test_fill();
        do_reset();
        rf_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b0, 2'b01, i[0], 2'b00, 1'b0, 1'b0, 5'(i), 32'(i * 3), 32'(i * 7));
        end
        idle();
        @(negedge clk);
        n_tests++;
        if ({fifo_lvl, err_ovf} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL fill_lvl: got lvl=%0d ovf=%b want 4 1", fifo_lvl, err_ovf);
        end
        @(posedge clk); #1; rf_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rf_req, rf_addr} !== {1'b1, 5'(i)}) begin
                n_fail++; $display("FAIL drain_order: got req=%b addr=%0d want 1 %0d", rf_req, rf_addr, i);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (fifo_lvl !== 3'd0) begin
            n_fail++; $display("FAIL drain_lvl: got %0d want 0", fifo_lvl);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        rf_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 1'b1, 2'b00, 1'b0, 2'b10, i[1], 1'b0, 5'(i), 32'(i), 32'(~i));
        end
        drv(1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 5'd9, 32'hDEAD_0009, 32'hBEEF_0009);
        rf_ack = 1'b1;
        idle();
        rf_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({fifo_lvl, err_ovf} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL full_pushpop: got lvl=%0d ovf=%b want 4 0", fifo_lvl, err_ovf);
        end
        @(posedge clk); #1; rf_ack = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (fifo_lvl !== 3'd0) begin
            n_fail++; $display("FAIL full_drain: got %0d want 0", fifo_lvl);
        end
    endtask

    task automatic test_proto();
        do_reset();
        rf_ack = 1'b1;
        drv(1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 5'd7, 32'd1, 32'd2);
        idle();
        @(negedge clk);
        n_tests++;
        if ({rf_req, err_proto, fifo_lvl} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL proto: got req=%b perr=%b lvl=%0d want 0 1 0", rf_req, err_proto, fifo_lvl);
        end
        drv(1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 5'd3, 32'd5, 32'd6);
        idle();
        @(negedge clk);
        n_tests++;
        if ({rf_req, fifo_lvl, err_ovf} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL no_ena_ignored: got req=%b lvl=%0d ovf=%b want 0 0 0", rf_req, fifo_lvl, err_ovf);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rf_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 5'(10 + i), 32'(i), 32'(i));
        end
        idle();
        @(negedge clk);
        n_tests++;
        if (fifo_lvl !== 3'd3) begin
            n_fail++; $display("FAIL mid_lvl: got %0d want 3", fifo_lvl);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; rf_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rf_req, fifo_lvl, sb_clr_stb} !== {1'b0, 3'd0, 1'b0}) begin
                n_fail++; $display("FAIL mid_reset: got req=%b lvl=%0d sb=%b want 0 0 0", rf_req, fifo_lvl, sb_clr_stb);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int mode;
        logic [1:0] ea, eb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 15);
            ea = 2'b00; eb = 2'b00;
            if (mode < 7)       ea = 2'($urandom_range(1, 3));
            else if (mode < 14) eb = 2'($urandom_range(1, 3));
            else if (mode == 15) begin
                ea = 2'($urandom_range(1, 3)); eb = 2'($urandom_range(1, 3));
            end else begin
                ea = 2'b00;
            end
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ea, 1'($urandom_range(0, 1)),
                eb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom, $urandom);
            rf_ack = ($urandom_range(0, 3) != 0);
        end
        idle();
        rf_ack = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({rf_req, fifo_lvl} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL b2b_drain: got req=%b lvl=%0d want 0 0", rf_req, fifo_lvl);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_thread_b();
        test_fill();
        test_full_pushpop();
        test_proto();
        test_reset_mid();
        test_back_to_back();
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
